// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson phase sequencer: width, FSM states and
// the eight legal phase codes in up-sequence order.
package johnson_pkg;

    localparam int unsigned JOHNSON_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [JOHNSON_W-1:0] PH_0 = 4'b0000;
    localparam logic [JOHNSON_W-1:0] PH_1 = 4'b1000;
    localparam logic [JOHNSON_W-1:0] PH_2 = 4'b1100;
    localparam logic [JOHNSON_W-1:0] PH_3 = 4'b1110;
    localparam logic [JOHNSON_W-1:0] PH_4 = 4'b1111;
    localparam logic [JOHNSON_W-1:0] PH_5 = 4'b0111;
    localparam logic [JOHNSON_W-1:0] PH_6 = 4'b0011;
    localparam logic [JOHNSON_W-1:0] PH_7 = 4'b0001;

endpackage

// File: rtl/johnson_next_phase.sv
// Combinational Johnson successor: up shifts right feeding ~LSB into the MSB,
// down shifts left feeding ~MSB into the LSB; any illegal code recovers to 0000.
module johnson_next_phase
    import johnson_pkg::*;
(
    input  logic [JOHNSON_W-1:0] cur,
    input  logic                 dir,
    output logic [JOHNSON_W-1:0] nxt
);

    logic legal;

    // Select the successor in the requested direction, forcing recovery from illegal codes
    always_comb begin
        legal = cur inside {PH_0, PH_1, PH_2, PH_3, PH_4, PH_5, PH_6, PH_7};
        nxt   = '0;
        if (legal) begin
            if (dir) begin
                nxt = {~cur[0], cur[JOHNSON_W-1:1]};
            end else begin
                nxt = {cur[JOHNSON_W-2:0], ~cur[JOHNSON_W-1]};
            end
        end
    end

endmodule

// File: rtl/johnson_step_ctrl.sv
// Command-driven Johnson phase sequencer: on start, advances the phase once
// every P cycles in the latched direction for N steps, then pulses done.
module johnson_step_ctrl
    import johnson_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dir,
    input  logic [CNT_W-1:0]     steps,
    input  logic [DIV_W-1:0]     period,
    input  logic                 abort,
    output logic [JOHNSON_W-1:0] phase,
    output logic                 step_pulse,
    output logic                 busy,
    output logic                 done
);

    state_t                 state_q;
    logic                   dir_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DIV_W-1:0]       per_q;
    logic [DIV_W-1:0]       timer_q;
    logic [JOHNSON_W-1:0]   phase_q;
    logic [JOHNSON_W-1:0]   phase_d;
    logic                   step_pulse_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   step_due;
    logic                   last_step;

    johnson_next_phase u_next (
        .cur (phase_q),
        .dir (dir_q),
        .nxt (phase_d)
    );

    // Step and terminal-count decode from the current timer and remaining count
    always_comb begin
        step_due  = (timer_q == (per_q - DIV_W'(1)));
        last_step = (cnt_q == CNT_W'(1));
    end

    // Command FSM with timer, step counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            cnt_q        <= '0;
            per_q        <= '0;
            timer_q      <= '0;
            phase_q      <= '0;
            step_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (steps != '0) begin
                            dir_q   <= dir;
                            cnt_q   <= steps;
                            per_q   <= (period == '0) ? DIV_W'(1) : period;
                            timer_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (step_due) begin
                        phase_q      <= phase_d;
                        step_pulse_q <= 1'b1;
                        cnt_q        <= cnt_q - CNT_W'(1);
                        timer_q      <= '0;
                        if (last_step) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        timer_q <= timer_q + DIV_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign phase      = phase_q;
    assign step_pulse = step_pulse_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
